// File: rtl/ysyx_24100005_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// A buffer entry is {err, pc, inst}.
package ysyx_24100005_ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h8000_0000;
    localparam int          IFU_DEPTH_DEFAULT = 2;
    localparam int          IFU_ENTRY_W       = 65;

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] inst;
    } ifu_entry_t;

    function automatic int ifu_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] ifu_align_pc(input logic [31:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/ysyx_24100005_ifu_if.sv
// Fetch-side bundle: memory request/response, core delivery and redirect.
// master = IFU side, slave = environment (memory + core).
interface ysyx_24100005_ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc, inst_err,
        input  inst_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc, inst_err,
        output inst_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_24100005_ifu_fifo.sv
// Instruction buffer: synchronous FIFO with flush; head is read straight
// from storage so a pushed entry becomes visible the following cycle.
module ysyx_24100005_ifu_fifo
    import ysyx_24100005_ifu_pkg::*;
#(
    parameter int DEPTH = IFU_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  ifu_entry_t                  data_i,
    output ifu_entry_t                  head_o,
    output logic [ifu_cnt_w(DEPTH)-1:0] count_o
);
    localparam int CNT_W = ifu_cnt_w(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    logic [IFU_ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // A full buffer may push and pop together: the read of the old head
    // happens this cycle, the overwrite lands on the clock edge.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = ifu_entry_t'(mem_q[rd_ptr_q]);
    assign count_o = count_q;

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: sequential fetch with credit-limited issue,
// in-order response buffering and redirect flush with in-flight drop count.
module ysyx_24100005_ifu
    import ysyx_24100005_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = IFU_DEPTH_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    ysyx_24100005_ifu_if.master  bus
);
    localparam int CNT_W = ifu_cnt_w(DEPTH);
    localparam int SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] in_use;
    logic [31:0]      redirect_target;
    logic             req_fire, rsp_fire, push, pop, credit_ok;
    ifu_entry_t       push_entry, head;

    assign redirect_target = ifu_align_pc(bus.redirect_pc);
    assign pop             = bus.inst_valid && bus.inst_ready;

    // Every slot is reserved at issue time, so a response can always be stored.
    assign in_use    = SUM_W'(outstanding_q) + SUM_W'(count) - SUM_W'(pop);
    assign credit_ok = in_use < SUM_W'(DEPTH);

    assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit_ok;
    assign bus.imem_req_addr  = rst ? RESET_PC : fetch_pc_q;

    assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire   = bus.imem_rsp_valid && !rst;
    assign push       = rsp_fire && (drop_q == '0) && !bus.redirect_valid;
    assign push_entry = '{err: bus.imem_rsp_err, pc: rsp_pc_q, inst: bus.imem_rsp_data};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
        if (push)     rsp_pc_d   = rsp_pc_q + 32'd4;
        if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
        // Everything still in flight after this cycle belongs to the old stream.
        if (bus.redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            drop_d     = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    ysyx_24100005_ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .data_i  (push_entry),
        .head_o  (head),
        .count_o (count)
    );

    assign bus.inst_valid = !rst && (count != '0);
    assign bus.inst       = bus.inst_valid ? head.inst : 32'h0;
    assign bus.inst_pc    = bus.inst_valid ? head.pc   : 32'h0;
    assign bus.inst_err   = bus.inst_valid && head.err;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Scoreboard bench for the fetch unit: accepted requests push expected entries,
// a negedge monitor pops and compares every delivered instruction.
module tb_ysyx_24100005_ifu;
    import ysyx_24100005_ifu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_24100005_ifu_if bus();

    ysyx_24100005_ifu #(
        .RESET_PC (32'h8000_0000),
        .DEPTH    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    exp_t        mon_e;
    int          checks = 0, errors = 0;
    int          cyc = 0, last_due = 0, req_cnt = 0, pop_cnt = 0;
    int          err08 = -1, err0c = -1;
    int          lat_min = 1, lat_max = 1;
    logic [31:0] model_pc = 32'h8000_0000;
    logic [31:0] err_addr = 32'h0000_0001;
    logic [31:0] last_req_addr = 32'h0;
    bit          rand_ready = 0, rand_req_ready = 0;
    bit          next_ready = 1, next_req_ready = 1, next_redir = 0;
    logic [31:0] next_target = 32'h0;

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return a ^ 32'h3C3C_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=none required=event", name);
    endtask

    // Monitor: compare every delivered instruction with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.inst_valid && bus.inst_ready) begin
            pop_cnt++;
            if (bus.inst_pc == 32'h8000_0008) err08 = int'(bus.inst_err);
            if (bus.inst_pc == 32'h8000_000C) err0c = int'(bus.inst_err);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst actual_pc=%h required=none", bus.inst_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("inst_pc", bus.inst_pc, mon_e.pc);
                chk("inst", bus.inst, mon_e.inst);
                chk("inst_err", 32'(bus.inst_err), 32'(mon_e.err));
            end
        end
    end

    // Record what happens in the current cycle, then step to the next one.
    task automatic cycle();
        int lat;
        int due;
        mem_t m;
        exp_t e;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_req_addr, model_pc);
            e.pc   = model_pc;
            e.inst = data_fn(model_pc);
            e.err  = (model_pc == err_addr);
            exp_q.push_back(e);
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            m.addr = bus.imem_req_addr;
            m.due  = due;
            mem_q.push_back(m);
            last_req_addr = bus.imem_req_addr;
            model_pc = model_pc + 32'd4;
            req_cnt++;
        end
        if (bus.redirect_valid) begin
            chk("req_suppressed", 32'(bus.imem_req_valid), 32'd0);
            exp_q.delete();
            model_pc = bus.redirect_pc & ~32'h3;
        end
        if (bus.imem_rsp_valid) void'(mem_q.pop_front());
        @(posedge clk);
        #1;
        cyc++;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = data_fn(mem_q[0].addr);
            bus.imem_rsp_err   = (mem_q[0].addr == err_addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
            bus.imem_rsp_err   = 1'b0;
        end
        bus.inst_ready     = rand_ready ? 1'($urandom_range(1, 0)) : next_ready;
        bus.imem_req_ready = rand_req_ready ? ($urandom_range(3, 0) != 0) : next_req_ready;
        bus.redirect_valid = next_redir;
        bus.redirect_pc    = next_target;
        next_redir = 0;
        @(negedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!bus.inst_valid && k < budget) begin
            cycle();
            k++;
        end
        if (!bus.inst_valid) timeout_fail(name);
    endtask

    task automatic wait_reqs(input string name, input int n, input int budget);
        int target = req_cnt + n;
        int k = 0;
        while (req_cnt < target && k < budget) begin
            cycle();
            k++;
        end
        if (req_cnt < target) timeout_fail(name);
    endtask

    task automatic redirect(input logic [31:0] pc);
        next_redir  = 1;
        next_target = pc;
        cycle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int r0;
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_rsp_err   = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h8000_0000);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_inst_err", 32'(bus.inst_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        @(negedge clk);
        #2;
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr", bus.imem_req_addr, 32'h8000_0000);

        // Sequential fetch from reset, 1-cycle memory, core always ready.
        wait_valid("first_inst", 10);
        for (int i = 0; i < 10; i++) begin
            chk("no_bubble", 32'(bus.inst_valid), 32'd1);
            cycle();
        end

        // Core stalled: only two requests may be issued.
        next_ready = 0;
        redirect(32'h8000_0200);
        r0 = req_cnt;
        run(12);
        chk("stall_req_count", 32'(req_cnt - r0), 32'd2);
        chk("stall_head_valid", 32'(bus.inst_valid), 32'd1);
        chk("stall_head_pc", bus.inst_pc, 32'h8000_0200);
        next_ready = 1;
        run(10);

        // Redirect with two requests in flight.
        lat_min = 4;
        lat_max = 4;
        redirect(32'h8000_0300);
        wait_reqs("inflight_reqs", 2, 30);
        redirect(32'h8000_0100);
        cycle();
        chk("valid_after_redirect", 32'(bus.inst_valid), 32'd0);
        wait_valid("redirect_inst", 30);
        chk("redirect_pc", bus.inst_pc, 32'h8000_0100);
        chk("redirect_data", bus.inst, data_fn(32'h8000_0100));
        run(10);

        // Redirect coinciding with a request and a response, unaligned target.
        lat_min = 1;
        lat_max = 1;
        run(8);
        redirect(32'h8000_0102);
        cycle();
        wait_reqs("restart_req", 1, 10);
        chk("restart_addr", last_req_addr, 32'h8000_0100);
        run(8);

        // Access fault on one beat only.
        err_addr = 32'h8000_0008;
        err08 = -1;
        err0c = -1;
        redirect(32'h8000_0000);
        run(15);
        chk("err_08", 32'(err08), 32'd1);
        chk("err_0c", 32'(err0c), 32'd0);

        // Address wrap-around.
        redirect(32'hFFFF_FFF8);
        run(12);
        chk("wrap_addr", 32'(last_req_addr < 32'h40), 32'd1);

        // Random latency, ready and redirects.
        lat_min = 1;
        lat_max = 4;
        rand_ready = 1;
        rand_req_ready = 1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(24, 0) == 0) begin
                next_redir  = 1;
                next_target = {16'h8000, 16'($urandom)};
            end
            cycle();
        end

        // Drain: stop accepting requests and empty everything.
        rand_ready = 0;
        rand_req_ready = 0;
        next_ready = 1;
        next_req_ready = 0;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || mem_q.size() != 0); i++) cycle();
        run(2);
        chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        chk("drain_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("pops_seen", 32'(pop_cnt > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
